// File: rtl/op_dest_router_pkg.sv
// Shared widths, destination names and helpers for the operand/opcode destination router.
package op_dest_router_pkg;

  localparam int unsigned DEF_NUM_DEST  = 4;
  localparam int unsigned DEF_SEL_W     = 2;
  localparam int unsigned DEF_DB_CYCLES = 250000;

  // Destination index names for the standard four-field build
  typedef enum logic [1:0] {
    DEST_ALU   = 2'd0,
    DEST_BS    = 2'd1,
    DEST_SHAMT = 2'd2,
    DEST_MUX   = 2'd3
  } dest_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/op_dest_router_if.sv
// Switch/button inputs and routed destination outputs of the op_dest_router.
interface op_dest_router_if
  import op_dest_router_pkg::*;
#(
  parameter int unsigned NUM_DEST = DEF_NUM_DEST,
  parameter int unsigned SEL_W    = DEF_SEL_W
);
  localparam int unsigned IDX_W = idx_width(NUM_DEST);

  logic                      btn_next;
  logic                      btn_prev;
  logic [SEL_W-1:0]          sel_in;
  logic                      hold;
  logic [NUM_DEST*SEL_W-1:0] dest_out;
  logic [IDX_W-1:0]          dest_idx;
  logic [NUM_DEST-1:0]       dest_onehot;
  logic                      dest_changed;

  modport master (
    output btn_next, btn_prev, sel_in, hold,
    input  dest_out, dest_idx, dest_onehot, dest_changed
  );

  modport slave (
    input  btn_next, btn_prev, sel_in, hold,
    output dest_out, dest_idx, dest_onehot, dest_changed
  );

endinterface

// File: rtl/op_dest_router_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, counter debounce on both edges, rising-edge strobe.
module btn_debounce
  import op_dest_router_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);
  localparam int unsigned CNT_W = (DB_CYCLES <= 2) ? 1 : $clog2(DB_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Level only follows the synchronized input after DB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_W'(DB_CYCLES - 1)) begin
          level <= sync2;
          rise  <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/op_dest_router.sv
// Routes sel_in into one of NUM_DEST registered fields; next/prev buttons pick the active field.
module op_dest_router
  import op_dest_router_pkg::*;
#(
  parameter int unsigned NUM_DEST  = DEF_NUM_DEST,
  parameter int unsigned SEL_W     = DEF_SEL_W,
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input logic            clk,
  input logic            rst,
  op_dest_router_if.slave bus
);
  localparam int unsigned IDX_W = idx_width(NUM_DEST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DEST - 1);

  logic             next_level;
  logic             next_rise;
  logic             prev_level;
  logic             prev_rise;
  logic             unused_levels;
  logic [IDX_W-1:0] idx_q;
  logic             changed_q;
  logic [SEL_W-1:0] field_q [NUM_DEST];

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_next),
    .level   (next_level),
    .rise    (next_rise)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_prev (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_prev),
    .level   (prev_level),
    .rise    (prev_rise)
  );

  assign unused_levels = next_level ^ prev_level;

  // Index stepping with wrap; coincident strobes cancel. Capture uses the pre-update index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      changed_q <= 1'b0;
      for (int k = 0; k < NUM_DEST; k++) field_q[k] <= '0;
    end else begin
      changed_q <= 1'b0;
      if (next_rise && !prev_rise) begin
        idx_q     <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        changed_q <= 1'b1;
      end else if (prev_rise && !next_rise) begin
        idx_q     <= (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
        changed_q <= 1'b1;
      end
      if (!bus.hold) field_q[idx_q] <= bus.sel_in;
    end
  end

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_flat
    assign bus.dest_out[k*SEL_W +: SEL_W] = field_q[k];
  end

  assign bus.dest_idx     = idx_q;
  assign bus.dest_changed = changed_q;
  assign bus.dest_onehot  = NUM_DEST'(1) << idx_q;

endmodule

// File: tb/tb_op_dest_router.sv
// Directed bench for op_dest_router: reset, stepping, wrap, bounce rejection, hold, reset mid-press.
module tb_op_dest_router;
  localparam int unsigned ND = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;

  op_dest_router_if #(.NUM_DEST(ND), .SEL_W(SW)) bus ();

  op_dest_router #(.NUM_DEST(ND), .SEL_W(SW), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge and counting dest_changed pulses
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.dest_changed === 1'b1) pulses++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    bus.sel_in   = 2'b11;
    bus.hold     = 1'b0;

    // 1: reset state, then field0 follows sel_in
    cycles(2);
    chk("rst_idx", 32'(bus.dest_idx), 32'd0);
    chk("rst_onehot", 32'(bus.dest_onehot), 32'h1);
    chk("rst_dest_out", 32'(bus.dest_out), 32'h00);
    chk("rst_changed", 32'(bus.dest_changed), 32'd0);
    rst = 1'b0;
    cycles(1);
    chk("t1_field0_first_edge", 32'(bus.dest_out), 32'h03);
    cycles(2);
    chk("t1_idx", 32'(bus.dest_idx), 32'd0);
    chk("t1_onehot", 32'(bus.dest_onehot), 32'h1);
    chk("t1_changed", 32'(bus.dest_changed), 32'd0);
    chk("t1_dest_out", 32'(bus.dest_out), 32'h03);

    // 2: long press gives exactly one step; new field tracks, old keeps value
    pulses = 0;
    bus.btn_next = 1'b1;
    cycles(20);
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_idx", 32'(bus.dest_idx), 32'd1);
    chk("t2_onehot", 32'(bus.dest_onehot), 32'h2);
    chk("t2_dest_out_held", 32'(bus.dest_out), 32'h0F);
    bus.sel_in = 2'b01;
    cycles(1);
    chk("t2_field1_track", 32'(bus.dest_out), 32'h07);
    bus.btn_next = 1'b0;
    pulses = 0;
    cycles(10);
    chk("t2_release_pulses", 32'(pulses), 32'd0);
    chk("t2_release_idx", 32'(bus.dest_idx), 32'd1);

    // 3: fresh reset, four presses wrap 1,2,3,0, then prev from 0 goes to 3
    rst = 1'b1;
    #1;
    chk("t3_async_rst_idx", 32'(bus.dest_idx), 32'd0);
    cycles(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulses = 0;
      bus.btn_next = 1'b1;
      cycles(10);
      bus.btn_next = 1'b0;
      cycles(10);
      chk($sformatf("t3_next_idx_%0d", i), 32'(bus.dest_idx), 32'((i + 1) % 4));
      chk($sformatf("t3_next_pulses_%0d", i), 32'(pulses), 32'd1);
    end
    pulses = 0;
    bus.btn_prev = 1'b1;
    cycles(10);
    bus.btn_prev = 1'b0;
    cycles(10);
    chk("t3_prev_wrap_idx", 32'(bus.dest_idx), 32'd3);
    chk("t3_prev_pulses", 32'(pulses), 32'd1);
    chk("t3_dest_out", 32'(bus.dest_out), 32'h55);

    // 4: bounce shorter than the debounce window is ignored
    bus.sel_in = 2'b10;
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      bus.btn_next = 1'b1;
      cycles(2);
      bus.btn_next = 1'b0;
      cycles(2);
    end
    cycles(10);
    chk("t4_bounce_idx", 32'(bus.dest_idx), 32'd3);
    chk("t4_bounce_pulses", 32'(pulses), 32'd0);
    chk("t4_dest_out", 32'(bus.dest_out), 32'h95);

    // 5: simultaneous buttons cancel; hold freezes every field
    pulses = 0;
    bus.btn_next = 1'b1;
    bus.btn_prev = 1'b1;
    cycles(10);
    chk("t5_both_idx", 32'(bus.dest_idx), 32'd3);
    chk("t5_both_pulses", 32'(pulses), 32'd0);
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    cycles(10);
    chk("t5_both_release_idx", 32'(bus.dest_idx), 32'd3);
    chk("t5_both_release_pulses", 32'(pulses), 32'd0);
    bus.hold = 1'b1;
    for (int v = 0; v < 4; v++) begin
      bus.sel_in = 2'(v);
      cycles(1);
      chk($sformatf("t5_hold_sel%0d", v), 32'(bus.dest_out), 32'h95);
    end
    bus.hold   = 1'b0;
    bus.sel_in = 2'b00;
    cycles(1);
    chk("t5_unhold_field3", 32'(bus.dest_out), 32'h15);

    // 6: async reset mid-count, button still held after release -> one step after DB+3 cycles
    bus.btn_next = 1'b1;
    cycles(3);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_idx", 32'(bus.dest_idx), 32'd0);
    chk("t6_rst_onehot", 32'(bus.dest_onehot), 32'h1);
    chk("t6_rst_dest_out", 32'(bus.dest_out), 32'h00);
    chk("t6_rst_changed", 32'(bus.dest_changed), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    cycles(DB + 2);
    chk("t6_before_step_idx", 32'(bus.dest_idx), 32'd0);
    cycles(1);
    chk("t6_step_idx", 32'(bus.dest_idx), 32'd1);
    chk("t6_step_changed", 32'(bus.dest_changed), 32'd1);
    cycles(20);
    chk("t6_held_idx", 32'(bus.dest_idx), 32'd1);
    chk("t6_held_pulses", 32'(pulses), 32'd1);
    bus.btn_next = 1'b0;
    cycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
